sha256_msg_schedule: RTL and testbench
======================================

// Module: sha256_msg_schedule
// PURPOSE
//   Loads one 512-bit SHA-256 block as sixteen 32-bit words over a valid/ready input.
//   Then emits the 64-word message schedule W[0..63] over a valid/ready output.
//   Sits between the block padder and the compression round engine.
//   Supplies the W_t term that the round adds alongside Sigma1(E), Ch, K_t, etc.
//   Words for t>=16 are expanded in place in a 16-entry circular buffer.
// PARAMETERS
//   WORD_W      32   word width; only 32 is supported
//   NUM_ROUNDS  64   schedule length; only 64 is supported
// PORTS
//   clk        in   1       single clock; all state updates on rising edge
//   rst        in   1       synchronous, active-high reset
//   in_valid   in   1       in_word holds a valid block word
//   in_ready   out  1       block accepts a word this cycle
//   in_word    in   32      block word, big-endian word order, M0 first
//   out_valid  out  1       out_word holds W[out_index]
//   out_ready  in   1       consumer takes out_word this cycle
//   out_word   out  32      schedule word W_t
//   out_index  out  6       t, 0..63
//   out_last   out  1       asserted with out_valid when out_index==63
// BEHAVIOUR
//   Reset values: state=LOAD, load count=0, t=0, in_ready=0, out_valid=0, out_last=0.
//     Buffer contents are don't-care. in_ready rises the cycle after rst deasserts.
//   State LOAD:
//     - in_ready=1, out_valid=0.
//     - Each in_valid&&in_ready writes buf[cnt] and increments cnt.
//     - On the 16th handshake (cnt==15): go to EXPAND, set t=0.
//     - in_ready is 0 from the next cycle; no word is accepted in the transition cycle.
//   State EXPAND:
//     - in_ready=0; in_valid is ignored.
//     - out_valid=1; out_word and out_index are driven from registered state only.
//     - First out_valid occurs one cycle after the 16th input handshake.
//   Word rule:
//     - t<16: W_t = buf[t].
//     - t>=16: W_t = s1(buf[(t-2)%16]) + buf[(t-7)%16] + s0(buf[(t-15)%16]) + buf[t%16].
//       The sum is mod 2^32; carries are discarded.
//     - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
//     - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
//   On out_valid&&out_ready:
//     - If t>=16, W_t is written to buf[t%16].
//     - t increments.
//     - After the handshake with t==63: state=LOAD, cnt=0; in_ready=1 the next cycle.
//   Stall: while out_ready=0, out_word, out_index and out_last hold; the buffer is not written.
//   W_t must be stable and correct for the whole valid window. A one-register pipeline
//     on out_word is allowed only if the first-valid latency above still holds.
//   Reset mid-operation (LOAD or EXPAND): abort immediately.
//     - Partial block and schedule are discarded; no further out_valid.
//   Throughput: 16 input cycles + 64 output cycles per block with no stalls.
//     - No overlap of LOAD and EXPAND.
// STRUCTURE
//   Shared package sha256_pkg:
//     - SHA_WORD_W=32, SHA_ROUNDS=64, SHA_BLOCK_WORDS=16.
//     - Rotate/shift amounts for s0/s1 (7,18,3 / 17,19,10).
//     - State encoding (LOAD, EXPAND).
//   One sub-module, func_small_sigma #(ROT_A, ROT_B, SHR_C).
//     - Built from right_cyclic_shift plus a logical shift; instanced twice, as s0 and s1.
//   The FSM, counters and the 16x32 buffer stay in this module.
// TESTING
//   1. "abc" block (W0=61626380, W1..W14=0, W15=00000018), no stalls:
//      - out_index 0..63 in order; W16=61626380, W17=000F0000, W18=7DA86405.
//      - All 64 words match the software model; out_last only at t=63.
//   2. Same block, out_ready toggled randomly 50%: identical 64-word sequence.
//      out_word and out_index are stable across every stall cycle.
//   3. in_valid held high during EXPAND with junk words:
//      - in_ready stays 0; output unaffected.
//      - After t=63 the next 16 words load, and a second block (all FFFFFFFF) matches the model.
//   4. rst pulsed after 8 loaded words, then again at t=30 of EXPAND:
//      - out_valid=0 and in_ready=1 the cycle after rst drops.
//      - A fresh full block then produces correct W0..W63.
//   5. Gapped input (in_valid 1 cycle in 3):
//      - Exactly 16 words accepted; out_valid rises one cycle after the 16th handshake, never earlier.
//   6. Back-to-back blocks with in_valid and out_ready tied high:
//      - 80 cycles per block.
//      - Carry wrap case: block of all FFFFFFFF gives W16 = model value (mod 2^32).

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM encoding and the rotate helper used by the
// message-schedule datapath.
package sha256_pkg;

    localparam int SHA_WORD_W      = 32;
    localparam int SHA_ROUNDS      = 64;
    localparam int SHA_BLOCK_WORDS = 16;

    localparam int SIG0_ROT_A = 7;
    localparam int SIG0_ROT_B = 18;
    localparam int SIG0_SHR_C = 3;
    localparam int SIG1_ROT_A = 17;
    localparam int SIG1_ROT_B = 19;
    localparam int SIG1_SHR_C = 10;

    typedef logic [SHA_WORD_W-1:0] sha_word_t;

    typedef enum logic {
        ST_LOAD   = 1'b0,
        ST_EXPAND = 1'b1
    } sched_state_e;

    // Rotating right is the low half of the doubled word shifted right.
    function automatic sha_word_t right_cyclic_shift(input sha_word_t x, input int unsigned amt);
        logic [2*SHA_WORD_W-1:0] dbl;
        dbl = {x, x} >> amt;
        return dbl[SHA_WORD_W-1:0];
    endfunction

endpackage

// File: rtl/func_small_sigma.sv
// Small sigma function of SHA-256: two right rotations XORed with a logical
// right shift. Instanced as s0 (7,18,3) and s1 (17,19,10).
module func_small_sigma
    import sha256_pkg::*;
#(
    parameter int ROT_A = SIG0_ROT_A,
    parameter int ROT_B = SIG0_ROT_B,
    parameter int SHR_C = SIG0_SHR_C
) (
    input  logic [SHA_WORD_W-1:0] x,
    output logic [SHA_WORD_W-1:0] y
);

    logic [SHA_WORD_W-1:0] rot_a;
    logic [SHA_WORD_W-1:0] rot_b;
    logic [SHA_WORD_W-1:0] shr_c;

    assign rot_a = right_cyclic_shift(x, ROT_A);
    assign rot_b = right_cyclic_shift(x, ROT_B);
    assign shr_c = x >> SHR_C;
    assign y     = rot_a ^ rot_b ^ shr_c;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads sixteen block words, then streams W[0..63],
// expanding words t>=16 in place in a 16-entry circular buffer.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int WORD_W     = SHA_WORD_W,
    parameter int NUM_ROUNDS = SHA_ROUNDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [5:0]        out_index,
    output logic              out_last
);

    localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);
    localparam logic [3:0] LAST_CNT = 4'(SHA_BLOCK_WORDS - 1);

    sched_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [5:0]   t_q, t_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;

    logic [WORD_W-1:0] wbuf_q [SHA_BLOCK_WORDS];
    logic              wbuf_we;
    logic [3:0]        wbuf_waddr;
    logic [WORD_W-1:0] wbuf_wdata;

    logic              in_fire;
    logic              out_fire;
    logic              t_expanding;
    logic [WORD_W-1:0] w_tm2;
    logic [WORD_W-1:0] w_tm7;
    logic [WORD_W-1:0] w_tm15;
    logic [WORD_W-1:0] w_tm16;
    logic [WORD_W-1:0] s0_out;
    logic [WORD_W-1:0] s1_out;
    logic [WORD_W-1:0] w_expanded;
    logic [WORD_W-1:0] w_t;

    assign in_fire     = in_valid && in_ready_q;
    assign out_fire    = out_valid_q && out_ready;
    assign t_expanding = (t_q[5:4] != 2'b00);

    // The 4-bit read indices wrap mod 16, which is exactly the circular-buffer offset.
    assign w_tm2  = wbuf_q[t_q[3:0] - 4'd2];
    assign w_tm7  = wbuf_q[t_q[3:0] - 4'd7];
    assign w_tm15 = wbuf_q[t_q[3:0] + 4'd1];
    assign w_tm16 = wbuf_q[t_q[3:0]];

    func_small_sigma #(
        .ROT_A (SIG0_ROT_A),
        .ROT_B (SIG0_ROT_B),
        .SHR_C (SIG0_SHR_C)
    ) u_s0 (
        .x (w_tm15),
        .y (s0_out)
    );

    func_small_sigma #(
        .ROT_A (SIG1_ROT_A),
        .ROT_B (SIG1_ROT_B),
        .SHR_C (SIG1_SHR_C)
    ) u_s1 (
        .x (w_tm2),
        .y (s1_out)
    );

    assign w_expanded = s1_out + w_tm7 + s0_out + w_tm16;
    assign w_t        = t_expanding ? w_expanded : w_tm16;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_word  = w_t;
    assign out_index = t_q;
    assign out_last  = out_valid_q && (t_q == LAST_T);

    // NOTE: state flops use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            t_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            t_q         <= t_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // NOTE: the word buffer has no reset; its contents are always written before being read.
    always_ff @(posedge clk) begin
        if (wbuf_we) begin
            wbuf_q[wbuf_waddr] <= wbuf_wdata;
        end
    end

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: begin
                if (in_fire && (cnt_q == LAST_CNT)) begin
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (out_fire && (t_q == LAST_T)) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        t_d         = t_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        wbuf_we     = 1'b0;
        wbuf_waddr  = cnt_q;
        wbuf_wdata  = in_word;
        unique case (state_q)
            ST_LOAD: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_fire) begin
                    wbuf_we = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        t_d         = '0;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_EXPAND: begin
                in_ready_d = 1'b0;
                if (out_fire) begin
                    wbuf_we    = t_expanding;
                    wbuf_waddr = t_q[3:0];
                    wbuf_wdata = w_expanded;
                    t_d        = t_q + 6'd1;
                    if (t_q == LAST_T) begin
                        cnt_d       = '0;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: random blocks and handshakes
// compared against a linear-array reference of the SHA-256 schedule.
module tb_sha256_msg_schedule;

    typedef logic [31:0] block_t [16];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic [5:0]  out_index;
    logic        out_last;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned first_fire_cyc = 0;
    logic [31:0] model_w [64];
    logic [31:0] obs_w [64];

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_index (out_index),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Textbook schedule over a flat 64-entry array.
    task automatic build_model(input block_t blk);
        for (int i = 0; i < 64; i++) begin
            if (i < 16) model_w[i] = blk[i];
            else model_w[i] = sig1(model_w[i-2]) + model_w[i-7] + sig0(model_w[i-15]) + model_w[i-16];
        end
    endtask

    task automatic random_block(output block_t blk);
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    // Loads a block then drains its schedule; abort_in / abort_t stop early for reset tests.
    task automatic run_block(input block_t blk, input int in_gap, input int rdy_pct,
                             input bit junk, input int abort_in, input int abort_t);
        int i = 0;
        int k = 0;
        int t = 0;
        int guard = 0;
        bit early = 1'b0;
        build_model(blk);
        while (i < 16 && i < abort_in) begin
            @(negedge clk);
            if (out_valid) early = 1'b1;
            in_valid  = ((k % in_gap) == 0);
            in_word   = in_valid ? blk[i] : $urandom;
            out_ready = ($urandom_range(99) < rdy_pct);
            k++;
            if (in_valid && in_ready) begin
                if (i == 0) first_fire_cyc = cyc;
                i++;
            end
            guard++;
            if (guard > 400) begin
                check("load_timeout", i, 16);
                in_valid = 1'b0;
                return;
            end
        end
        check("no_early_valid", {31'b0, early}, 32'd0);
        if (i < 16) return;
        guard = 0;
        while (t < 64) begin
            @(negedge clk);
            in_valid  = junk;
            in_word   = $urandom;
            out_ready = ($urandom_range(99) < rdy_pct);
            check("ctl_valid_last_ready", {29'b0, out_valid, out_last, in_ready},
                  {29'b0, 1'b1, (t == 63), 1'b0});
            check("index", {26'b0, out_index}, t);
            check("word", out_word, model_w[t]);
            if (t == abort_t) begin
                in_valid = 1'b0;
                return;
            end
            if (out_valid && out_ready) begin
                obs_w[t] = out_word;
                t++;
            end
            guard++;
            if (guard > 2000) begin
                check("expand_timeout", t, 64);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("rst_hold", {30'b0, out_valid, in_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release", {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        block_t abc;
        block_t ones;
        block_t blk_a;
        block_t blk_b;
        int unsigned stamp_a;
        int unsigned stamp_b;

        for (int i = 0; i < 16; i++) begin
            abc[i]  = '0;
            ones[i] = 32'hFFFF_FFFF;
        end
        abc[0]  = 32'h6162_6380;
        abc[15] = 32'h0000_0018;

        repeat (3) @(negedge clk);
        check("reset_outputs", {29'b0, out_valid, out_last, in_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {30'b0, out_valid, in_ready}, 32'd1);

        run_block(abc, 1, 100, 1'b0, 16, 64);
        check("abc_W0", obs_w[0], 32'h6162_6380);
        check("abc_W16", obs_w[16], 32'h6162_6380);
        check("abc_W17", obs_w[17], 32'h000F_0000);
        check("abc_W18", obs_w[18], 32'h7DA8_6405);

        run_block(abc, 1, 50, 1'b0, 16, 64);
        check("abc_stall_W18", obs_w[18], 32'h7DA8_6405);

        random_block(blk_a);
        run_block(blk_a, 1, 100, 1'b1, 16, 64);
        run_block(ones, 1, 60, 1'b0, 16, 64);

        random_block(blk_a);
        run_block(blk_a, 1, 100, 1'b0, 8, 64);
        do_reset();
        random_block(blk_a);
        run_block(blk_a, 1, 70, 1'b0, 16, 30);
        do_reset();
        random_block(blk_a);
        run_block(blk_a, 1, 100, 1'b0, 16, 64);

        random_block(blk_a);
        run_block(blk_a, 3, 100, 1'b0, 16, 64);

        random_block(blk_a);
        random_block(blk_b);
        run_block(blk_a, 1, 100, 1'b0, 16, 64);
        stamp_a = first_fire_cyc;
        run_block(blk_b, 1, 100, 1'b0, 16, 64);
        stamp_b = first_fire_cyc;
        check("b2b_period_ab", stamp_b - stamp_a, 32'd80);
        run_block(ones, 1, 100, 1'b0, 16, 64);
        check("b2b_period_b1", first_fire_cyc - stamp_b, 32'd80);
        check("ones_W16_wrap", obs_w[16], 32'h203F_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
